// File: rtl/apb_bridge_ctrl_param.sv
`default_nettype none
// ===== apb_bridge_ctrl_param : AHB-to-APB bridge, posted-write FIFO, APB wait/error handling =====
// ===== Rev 1.0 ==================================================================================
module apb_bridge_ctrl_param #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NSLV       = 4,
  parameter int SEL_LSB    = 12,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic              wr_err,
  input  logic              wr_err_clr
);
  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int PTRW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNTW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_RDONE, S_ERR1, S_ERR2
  } state_t;

  state_t              r_state;
  logic                r_wpend;
  logic [ADDR_W-1:0]   r_wpend_addr;
  logic                r_rdreq;
  logic                r_rd_busy;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [CNTW-1:0]     r_cnt;
  logic [PTRW-1:0]     r_wr_ptr;
  logic [PTRW-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0]   r_fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [WBUF_DEPTH];

  logic                w_accept;
  logic                w_launch;
  logic                w_pop;
  logic                w_rd_go;
  logic                w_wr_err_set;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  function automatic logic [IDXW-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[SEL_LSB +: IDXW];
  endfunction

  function automatic logic idx_bad(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(idx_of(a));
    return w >= 32'(NSLV);
  endfunction

  function automatic logic [NSLV-1:0] sel_of(input logic [ADDR_W-1:0] a);
    logic [NSLV-1:0] s;
    logic [31:0]     w;
    w = 32'(idx_of(a));
    for (int i = 0; i < NSLV; i++) s[i] = (w == 32'(i));
    return s;
  endfunction

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(WBUF_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign Hreadyout   = !r_rd_busy && (r_state != S_ERR1) &&
                       ((32'(r_cnt) + 32'(r_wpend)) < 32'(WBUF_DEPTH));
  assign Hresp       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign w_accept    = valid && Hreadyout;
  // A finished write may start the next job directly, giving back-to-back APB accesses.
  assign w_launch    = (r_state == S_IDLE) || ((r_state == S_ACCESS) && Pready && Pwrite);
  assign w_pop       = w_launch && (r_cnt != '0);
  assign w_rd_go     = w_launch && (r_cnt == '0) && !r_wpend && r_rdreq;
  assign w_wr_err_set = ((r_state == S_ACCESS) && Pready && Pwrite && Pslverr) ||
                        (w_pop && idx_bad(w_head_addr));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_wpend      <= 1'b0;
      r_wpend_addr <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_wpend <= w_accept && Hwrite;
      if (w_accept && Hwrite) r_wpend_addr <= Haddr;
      if (r_wpend) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + CNTW'(r_wpend) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge Hclk) begin
    if (r_wpend) begin
      r_fifo_addr[r_wr_ptr] <= r_wpend_addr;
      r_fifo_data[r_wr_ptr] <= Hwdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state   <= S_IDLE;
      r_rdreq   <= 1'b0;
      r_rd_busy <= 1'b0;
      r_rd_addr <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hrdata    <= '0;
      wr_err    <= 1'b0;
    end else begin
      if (w_accept && !Hwrite) begin
        r_rdreq   <= 1'b1;
        r_rd_busy <= 1'b1;
        r_rd_addr <= Haddr;
      end
      if (w_wr_err_set) wr_err <= 1'b1;
      else if (wr_err_clr) wr_err <= 1'b0;

      case (r_state)
        S_SETUP: begin
          r_state <= S_ACCESS;
          Penable <= 1'b1;
        end
        S_ACCESS: begin
          if (Pready && !Pwrite) begin
            Pselx     <= '0;
            Penable   <= 1'b0;
            r_rd_busy <= 1'b0;
            if (Pslverr) begin
              r_state <= S_ERR1;
            end else begin
              Hrdata  <= Prdata;
              r_state <= S_RDONE;
            end
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        S_RDONE: r_state <= S_IDLE;
        S_ERR2:  r_state <= S_IDLE;
        default: ;
      endcase

      if (w_launch) begin
        Penable <= 1'b0;
        if (w_pop) begin
          if (idx_bad(w_head_addr)) begin
            Pselx   <= '0;
            r_state <= S_IDLE;
          end else begin
            Pselx   <= sel_of(w_head_addr);
            Paddr   <= w_head_addr;
            Pwdata  <= w_head_data;
            Pwrite  <= 1'b1;
            r_state <= S_SETUP;
          end
        end else if (w_rd_go) begin
          r_rdreq <= 1'b0;
          if (idx_bad(r_rd_addr)) begin
            Pselx     <= '0;
            r_rd_busy <= 1'b0;
            r_state   <= S_ERR1;
          end else begin
            Pselx   <= sel_of(r_rd_addr);
            Paddr   <= r_rd_addr;
            Pwrite  <= 1'b0;
            r_state <= S_SETUP;
          end
        end else begin
          Pselx   <= '0;
          r_state <= S_IDLE;
        end
      end
    end
  end
endmodule
`default_nettype wire
